// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl: controller for one single-delay-feedback FFT stage.
// It sequences the delay lane through fill, butterfly run and drain, and
// decodes the butterfly phase and twiddle address from the in-frame sample
// counter.
// Optional build macro: SDF_CTRL_FRAME_CNT_EN adds a 16-bit frame_cnt output
// that counts completed frames.
module sdf_stage_ctrl #(
  parameter int unsigned DELAY_LEN = 8,
  parameter int unsigned CW        = $clog2(DELAY_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          flush,
  output logic          in_ready,
  output logic          dl_en,
  output logic          bf_sel,
  output logic          zero_sel,
  output logic [CW-1:0] tw_addr,
  output logic          out_valid,
  output logic          frame_done,
  output logic          busy
`ifdef SDF_CTRL_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  // Sample counter spans one frame (2*DELAY_LEN); phase counters span half.
  localparam int unsigned CNTW      = CW + 1;
  localparam int unsigned LW        = (DELAY_LEN > 2) ? $clog2(DELAY_LEN) : 1;
  localparam int unsigned FRAME_LEN = 2 * DELAY_LEN;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q,   cnt_d;
  logic [LW-1:0]   fill_q,  fill_d;
  logic [LW-1:0]   fcnt_q,  fcnt_d;

  logic            accept;
  logic            flushing;
  logic            last_in_frame;

  // Handshake, lane enable and phase decode; everything is forced low in reset.
  always_comb begin
    flushing      = !rst && (state_q == S_FLUSH);
    in_ready      = !rst && (state_q != S_FLUSH);
    accept        = in_valid && in_ready;
    dl_en         = accept || flushing;
    last_in_frame = (cnt_q == CNTW'(FRAME_LEN - 1));
    bf_sel        = !rst && (cnt_q >= CNTW'(DELAY_LEN));
    tw_addr       = rst ? '0 : cnt_q[CW-1:0];
    zero_sel      = flushing;
    out_valid     = dl_en && ((state_q == S_RUN) || (state_q == S_FLUSH));
    frame_done    = dl_en && last_in_frame;
    busy          = !rst && (state_q != S_IDLE);
  end

  // Next-state and counter update; counters only move on lane-enable cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    fcnt_d  = fcnt_q;

    if (dl_en) begin
      cnt_d = last_in_frame ? '0 : cnt_q + CNTW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        // First accepted sample is fill sample 1.
        if (accept) begin
          state_d = S_FILL;
          fill_d  = LW'(1);
        end
      end
      S_FILL: begin
        if (accept) begin
          if (fill_q == LW'(DELAY_LEN - 1)) begin
            state_d = S_RUN;
            fill_d  = '0;
          end else begin
            fill_d = fill_q + LW'(1);
          end
        end
      end
      S_RUN: begin
        // A coincident sample is still taken this cycle via accept above.
        if (flush) begin
          state_d = S_FLUSH;
          fcnt_d  = '0;
        end
      end
      S_FLUSH: begin
        if (fcnt_q == LW'(DELAY_LEN - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + LW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fill_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      fcnt_q  <= fcnt_d;
    end
  end

`ifdef SDF_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Completed-frame counter; wraps naturally at 16 bits and survives a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (frame_done) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Bench for sdf_stage_ctrl with DELAY_LEN=4: directed scenarios with literal
// expectations followed by random stimulus, all checked against a stream-level
// model (samples taken, frame position, drain cycles remaining).
module tb_sdf_stage_ctrl;

  localparam int DL = 4;
  localparam int CWT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic in_ready, dl_en, bf_sel, zero_sel, out_valid, frame_done, busy;
  logic [CWT-1:0] tw_addr;
`ifdef SDF_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  sdf_stage_ctrl #(.DELAY_LEN(DL), .CW(CWT)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .flush      (flush),
    .in_ready   (in_ready),
    .dl_en      (dl_en),
    .bf_sel     (bf_sel),
    .zero_sel   (zero_sel),
    .tw_addr    (tw_addr),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .busy       (busy)
`ifdef SDF_CTRL_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Stream model: samples taken this stream (saturating at DL), position in
  // frame, drain cycles still owed, completed frames.
  int m_samples = 0;
  int m_pos = 0;
  int m_flush_left = 0;
  int m_frames = 0;

  // Values seen on the last step, for the literal scenario checks.
  int s_rdy, s_dl, s_bf, s_zero, s_tw, s_ov, s_fd, s_busy;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock: drive, compare against model mid-cycle, then advance the model.
  task automatic step(input bit v, input bit f, input bit r);
    bit m_fl, m_idle, m_run;
    int e_rdy, e_dl, e_bf, e_zero, e_tw, e_ov, e_fd, e_busy;
    @(negedge clk);
    in_valid = v;
    flush    = f;
    rst      = r;
    #1;
    m_fl   = (m_flush_left > 0);
    m_idle = !m_fl && (m_samples == 0);
    m_run  = !m_fl && (m_samples >= DL);
    if (r) begin
      e_rdy = 0; e_dl = 0; e_bf = 0; e_zero = 0; e_tw = 0; e_ov = 0; e_fd = 0; e_busy = 0;
    end else begin
      e_rdy  = m_fl ? 0 : 1;
      e_dl   = ((v && !m_fl) || m_fl) ? 1 : 0;
      e_bf   = (m_pos >= DL) ? 1 : 0;
      e_tw   = m_pos % DL;
      e_zero = m_fl ? 1 : 0;
      e_ov   = (e_dl == 1 && (m_run || m_fl)) ? 1 : 0;
      e_fd   = (e_dl == 1 && m_pos == 2*DL-1) ? 1 : 0;
      e_busy = m_idle ? 0 : 1;
    end
    s_rdy = int'(in_ready); s_dl = int'(dl_en); s_bf = int'(bf_sel);
    s_zero = int'(zero_sel); s_tw = int'(tw_addr); s_ov = int'(out_valid);
    s_fd = int'(frame_done); s_busy = int'(busy);
    chk("in_ready",   s_rdy,  e_rdy);
    chk("dl_en",      s_dl,   e_dl);
    chk("bf_sel",     s_bf,   e_bf);
    chk("zero_sel",   s_zero, e_zero);
    chk("tw_addr",    s_tw,   e_tw);
    chk("out_valid",  s_ov,   e_ov);
    chk("frame_done", s_fd,   e_fd);
    chk("busy",       s_busy, e_busy);
`ifdef SDF_CTRL_FRAME_CNT_EN
    chk("frame_cnt", int'(frame_cnt), r ? int'(frame_cnt) : m_frames);
`endif
    @(posedge clk);
    if (r) begin
      m_samples = 0; m_pos = 0; m_flush_left = 0; m_frames = 0;
    end else begin
      if (e_fd == 1) m_frames = (m_frames + 1) % 65536;
      if (e_dl == 1) m_pos = (m_pos + 1) % (2*DL);
      if (m_fl) begin
        m_flush_left--;
        if (m_flush_left == 0) begin
          m_samples = 0;
          m_pos = 0;
        end
      end else begin
        if (v && m_samples < DL) m_samples++;
        if (m_run && f) m_flush_left = DL;
      end
    end
  endtask

  initial begin : main
    int exp_ov [8] = '{0,0,0,0,1,1,1,1};
    int exp_tw [8] = '{0,1,2,3,0,1,2,3};
    int exp_fd [8] = '{0,0,0,0,0,0,0,1};
    int gap_v  [4] = '{1,0,0,1};
    int gap_tw [4] = '{0,1,1,1};
    int gap_ov [4] = '{1,0,0,1};

    // Reset: everything low while held.
    step(0, 0, 1);
    step(0, 0, 1);
    chk("lit_reset_ready", s_rdy, 0);
    step(0, 0, 0);
    chk("lit_idle_ready", s_rdy, 1);
    chk("lit_idle_busy",  s_busy, 0);

    // Eight back-to-back samples: fill then one butterfly half.
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0);
      chk("lit_b2b_ov", s_ov, exp_ov[i]);
      chk("lit_b2b_bf", s_bf, (i >= 4) ? 1 : 0);
      chk("lit_b2b_tw", s_tw, exp_tw[i]);
      chk("lit_b2b_fd", s_fd, exp_fd[i]);
    end

    // Gaps in RUN hold the counter.
    for (int i = 0; i < 4; i++) begin
      step(gap_v[i] != 0, 0, 0);
      chk("lit_gap_tw", s_tw, gap_tw[i]);
      chk("lit_gap_ov", s_ov, gap_ov[i]);
    end

    // One-cycle flush, then four drain cycles with valid ignored.
    step(0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0);
      chk("lit_fl_ready", s_rdy, 0);
      chk("lit_fl_dl",    s_dl, 1);
      chk("lit_fl_zero",  s_zero, 1);
      chk("lit_fl_ov",    s_ov, 1);
    end
    step(0, 0, 0);
    chk("lit_post_fl_busy", s_busy, 0);
    chk("lit_post_fl_tw",   s_tw, 0);

    // Flush ignored in IDLE and mid-FILL.
    step(0, 1, 0);
    chk("lit_idle_flush_busy", s_busy, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    chk("lit_fill_flush_ready", s_rdy, 1);
    chk("lit_fill_flush_busy",  s_busy, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("lit_fill_last_ov", s_ov, 0);
    step(1, 0, 0);
    chk("lit_run_first_ov", s_ov, 1);

    // Reset in the second drain cycle, then a fresh stream.
    step(1, 1, 0);
    step(0, 0, 0);
    chk("lit_fl1_zero", s_zero, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("lit_rst_busy",  s_busy, 0);
    chk("lit_rst_ready", s_rdy, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0);
      chk("lit_refill_ov", s_ov, (i >= 4) ? 1 : 0);
    end

`ifdef SDF_CTRL_FRAME_CNT_EN
    // Three full frames, then a drain: count stays at 3.
    step(0, 0, 1);
    for (int i = 0; i < 24; i++) step(1, 0, 0);
    chk("lit_frame_cnt_3", int'(frame_cnt), 3);
    step(0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    chk("lit_frame_cnt_hold", int'(frame_cnt), 3);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
